// File: rtl/cla_nibble_sequencer_if.sv
// Operand/result handshake bundle for the nibble-serial CLA sequencer.
// The ovf signal exists only when CLA_SEQ_OVF_EN is defined.
interface cla_nibble_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
`ifdef CLA_SEQ_OVF_EN
  logic             ovf;
`endif

  // Producer of operands / consumer of results
  modport master (
    output in_valid, op_a, op_b, op_cin, out_ready,
    input  in_ready, out_valid, result, cout
`ifdef CLA_SEQ_OVF_EN
    , input ovf
`endif
  );

  // The sequencer itself
  modport slave (
    input  in_valid, op_a, op_b, op_cin, out_ready,
    output in_ready, out_valid, result, cout
`ifdef CLA_SEQ_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/cla_nibble_sequencer.sv
// Nibble-serial adder controller driving an external 4-bit CLA stage, LSB nibble first.
// Optional signed-overflow output enabled by defining CLA_SEQ_OVF_EN.
module cla_nibble_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  cla_nibble_sequencer_if.slave        bus,
  output logic [3:0]                   cla_a,
  output logic [3:0]                   cla_b,
  output logic                         cla_cin,
  input  logic [3:0]                   cla_s,
  input  logic                         cla_cout
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int unsigned REST = WIDTH - 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [IDXW-1:0] idx;
  // Upper operand nibbles not yet presented to the CLA stage
  logic [REST-1:0] a_rest;
  logic [REST-1:0] b_rest;

  // cla_cin doubles as the inter-nibble carry register
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      a_rest        <= '0;
      b_rest        <= '0;
      cla_a         <= 4'h0;
      cla_b         <= 4'h0;
      cla_cin       <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.cout      <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      bus.ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            cla_a        <= bus.op_a[3:0];
            cla_b        <= bus.op_b[3:0];
            cla_cin      <= bus.op_cin;
            a_rest       <= bus.op_a[WIDTH-1:4];
            b_rest       <= bus.op_b[WIDTH-1:4];
            idx          <= '0;
            bus.result   <= '0;
            bus.in_ready <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
            bus.ovf      <= 1'b0;
`endif
            state        <= RUN;
          end
        end

        RUN: begin
          bus.result[4*idx +: 4] <= cla_s;
          if (idx == IDXW'(NIB - 1)) begin
            bus.cout      <= cla_cout;
`ifdef CLA_SEQ_OVF_EN
            // cla_a/cla_b hold the top nibble here, so bit 3 is the operand sign
            bus.ovf       <= (cla_a[3] == cla_b[3]) && (cla_s[3] != cla_a[3]);
`endif
            bus.out_valid <= 1'b1;
            cla_a         <= 4'h0;
            cla_b         <= 4'h0;
            cla_cin       <= 1'b0;
            state         <= DONE;
          end else begin
            idx     <= idx + 1'b1;
            cla_a   <= a_rest[3:0];
            cla_b   <= b_rest[3:0];
            cla_cin <= cla_cout;
            a_rest  <= a_rest >> 4;
            b_rest  <= b_rest >> 4;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
